// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH/DECODE/EXECUTE/MEM/WB/HALT sequencer with retired-instruction counter.
// Optional macro UC_JAL_EN makes opcode 1101111 (jal) legal; otherwise it halts like any illegal opcode.
module uc_multiciclo (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [6:0]  opcode,
  output logic        weIR,
  output logic        wePC,
  output logic        weReg,
  output logic        weMem,
  output logic        sinalMux1,
  output logic [1:0]  sinalMux2,
  output logic        sinalMux4,
  output logic [1:0]  aluop,
  output logic        jump,
  output logic        done,
  output logic        erro,
  output logic [15:0] instr_count
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;

  state_t      state, state_nxt;
  logic [6:0]  opcode_q;
  logic [15:0] instr_count_q;
  logic        is_r, is_ld, is_st, is_beq, is_jal, legal;

  assign is_r   = (opcode_q == OP_R);
  assign is_ld  = (opcode_q == OP_LD);
  assign is_st  = (opcode_q == OP_ST);
  assign is_beq = (opcode_q == OP_BEQ);
`ifdef UC_JAL_EN
  assign is_jal = (opcode_q == OP_JAL);
`else
  assign is_jal = 1'b0;
`endif
  assign legal  = is_r | is_ld | is_st | is_beq | is_jal;

  assign instr_count = instr_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= FETCH;
      opcode_q      <= '0;
      instr_count_q <= '0;
    end else begin
      state <= state_nxt;
      if (weIR) opcode_q <= opcode;
      if (done) instr_count_q <= instr_count_q + 16'd1;
    end
  end

  // Outputs are qualified by reset so enables drop the moment reset is asserted,
  // even though FETCH with run=1 would otherwise raise weIR combinationally.
  always_comb begin
    state_nxt = state;
    weIR      = 1'b0;
    wePC      = 1'b0;
    weReg     = 1'b0;
    weMem     = 1'b0;
    sinalMux1 = 1'b0;
    sinalMux2 = 2'b00;
    sinalMux4 = 1'b0;
    aluop     = 2'b00;
    jump      = 1'b0;
    done      = 1'b0;
    erro      = 1'b0;
    if (reset) begin
      case (state)
        FETCH: begin
          if (run) begin
            weIR      = 1'b1;
            state_nxt = DECODE;
          end
        end
        DECODE: state_nxt = legal ? EXECUTE : HALT;
        EXECUTE: begin
          if (is_r) begin
            aluop     = 2'b10;
            state_nxt = WB;
          end else if (is_ld || is_st) begin
            sinalMux1 = 1'b1;
            state_nxt = MEM;
          end else if (is_beq) begin
            aluop     = 2'b01;
            sinalMux4 = 1'b1;
            wePC      = 1'b1;
            done      = 1'b1;
            state_nxt = FETCH;
          end else if (is_jal) begin
            sinalMux4 = 1'b1;
            state_nxt = WB;
          end else begin
            state_nxt = HALT;
          end
        end
        MEM: begin
          sinalMux1 = 1'b1;
          if (is_st) begin
            weMem     = 1'b1;
            wePC      = 1'b1;
            done      = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
        WB: begin
          weReg     = 1'b1;
          wePC      = 1'b1;
          done      = 1'b1;
          state_nxt = FETCH;
          if (is_r) begin
            aluop     = 2'b10;
            sinalMux2 = 2'b01;
          end else if (is_ld) begin
            sinalMux1 = 1'b1;
            sinalMux2 = 2'b00;
          end else begin
            sinalMux4 = 1'b1;
            jump      = 1'b1;
            sinalMux2 = 2'b10;
          end
        end
        HALT: erro = 1'b1;
        default: state_nxt = HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Scoreboard bench for uc_multiciclo: driver queues hand-computed per-cycle outputs, monitor checks on negedge.
// Expectations for opcode 1101111 follow the UC_JAL_EN macro.
module tb_uc_multiciclo;

  logic        clock, reset, run;
  logic [6:0]  opcode;
  logic        weIR, wePC, weReg, weMem, sinalMux1, sinalMux4, jump, done, erro;
  logic [1:0]  sinalMux2, aluop;
  logic [15:0] instr_count;

  uc_multiciclo dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode),
    .weIR(weIR), .wePC(wePC), .weReg(weReg), .weMem(weMem),
    .sinalMux1(sinalMux1), .sinalMux2(sinalMux2), .sinalMux4(sinalMux4),
    .aluop(aluop), .jump(jump), .done(done), .erro(erro),
    .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [12:0] outs;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [12:0] act;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cnt;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Bit order: weIR wePC weReg weMem mux1 mux2[1:0] mux4 aluop[1:0] jump done erro
  function automatic logic [12:0] v(input logic ir, pc, rg, mm, m1, input logic [1:0] m2,
                                    input logic m4, input logic [1:0] alu, input logic jmp, dn, er);
    return {ir, pc, rg, mm, m1, m2, m4, alu, jmp, dn, er};
  endfunction

  logic [12:0] ZERO, FETCH_GO, R_EX, R_WB, LD_EX, LD_MEM, LD_WB, ST_EX, ST_MEM, BEQ_EX,
               JAL_EX, JAL_WB, HALT_V;

  initial begin
    ZERO     = '0;
    FETCH_GO = v(1,0,0,0,0,2'b00,0,2'b00,0,0,0);
    R_EX     = v(0,0,0,0,0,2'b00,0,2'b10,0,0,0);
    R_WB     = v(0,1,1,0,0,2'b01,0,2'b10,0,1,0);
    LD_EX    = v(0,0,0,0,1,2'b00,0,2'b00,0,0,0);
    LD_MEM   = v(0,0,0,0,1,2'b00,0,2'b00,0,0,0);
    LD_WB    = v(0,1,1,0,1,2'b00,0,2'b00,0,1,0);
    ST_EX    = v(0,0,0,0,1,2'b00,0,2'b00,0,0,0);
    ST_MEM   = v(0,1,0,1,1,2'b00,0,2'b00,0,1,0);
    BEQ_EX   = v(0,1,0,0,0,2'b00,1,2'b01,0,1,0);
    JAL_EX   = v(0,0,0,0,0,2'b00,1,2'b00,0,0,0);
    JAL_WB   = v(0,1,1,0,0,2'b10,1,2'b00,1,1,0);
    HALT_V   = v(0,0,0,0,0,2'b00,0,2'b00,0,0,1);
  end

  always @(negedge clock) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      act = {weIR, wePC, weReg, weMem, sinalMux1, sinalMux2, sinalMux4, aluop, jump, done, erro};
      checks++;
      if (act !== mon_e.outs || instr_count !== mon_e.cnt) begin
        errors++;
        $display("FAIL %s: outs=%b required=%b instr_count=%h required=%h",
                 mon_e.name, act, mon_e.outs, instr_count, mon_e.cnt);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic r, input logic [6:0] op,
                      input logic [12:0] e);
    @(posedge clock);
    #1;
    reset  = rst;
    run    = r;
    opcode = op;
    q.push_back('{nm, e, cnt});
  endtask

  // FETCH + DECODE, then n tail states; later opcode inputs are junk to prove the opcode is latched.
  task automatic run_instr(input string nm, input logic [6:0] op, input int unsigned n,
                           input logic [12:0] t0, t1, t2);
    logic [12:0] tail [3];
    tail[0] = t0; tail[1] = t1; tail[2] = t2;
    step({nm, "_fetch"}, 1'b1, 1'b1, op, FETCH_GO);
    step({nm, "_decode"}, 1'b1, 1'b1, OP_BAD, ZERO);
    for (int unsigned i = 0; i < n; i++)
      step($sformatf("%s_s%0d", nm, i), 1'b1, 1'b1, OP_BAD, tail[i]);
    cnt = cnt + 16'd1;
  endtask

  task automatic illegal_and_reset();
    step("bad_fetch", 1'b1, 1'b1, OP_BAD, FETCH_GO);
    step("bad_decode", 1'b1, 1'b1, OP_R, ZERO);
    for (int i = 0; i < 20; i++)
      step($sformatf("halt_%0d", i), 1'b1, 1'b1, OP_R, HALT_V);
    cnt = '0;
    step("halt_reset", 1'b0, 1'b1, OP_R, ZERO);
    step("halt_release", 1'b1, 1'b0, OP_R, ZERO);
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; opcode = '0; cnt = '0;
    step("rst_run_gated", 1'b0, 1'b1, OP_R, ZERO);
    step("rst_hold", 1'b0, 1'b0, OP_R, ZERO);
    step("idle_after_rst", 1'b1, 1'b0, OP_R, ZERO);

    run_instr("r", OP_R, 2, R_EX, R_WB, ZERO);
    step("cnt_after_r", 1'b1, 1'b0, OP_R, ZERO);
    run_instr("load", OP_LD, 3, LD_EX, LD_MEM, LD_WB);
    run_instr("store", OP_ST, 2, ST_EX, ST_MEM, ZERO);
    step("cnt_after_ldst", 1'b1, 1'b0, OP_R, ZERO);
    run_instr("beq", OP_BEQ, 1, BEQ_EX, ZERO, ZERO);
    step("cnt_after_beq", 1'b1, 1'b0, OP_R, ZERO);

    @(posedge clock);
    #1;
    run = 1'b0;
    force dut.instr_count_q = 16'hFFFF;
    #1;
    release dut.instr_count_q;
    cnt = 16'hFFFF;
    q.push_back('{"wrap_preload", ZERO, cnt});
    run_instr("beq_wrap", OP_BEQ, 1, BEQ_EX, ZERO, ZERO);
    step("cnt_wrapped", 1'b1, 1'b0, OP_R, ZERO);

`ifdef UC_JAL_EN
    run_instr("jal", OP_JAL, 2, JAL_EX, JAL_WB, ZERO);
    step("cnt_after_jal", 1'b1, 1'b0, OP_R, ZERO);
`else
    step("jal_fetch", 1'b1, 1'b1, OP_JAL, FETCH_GO);
    step("jal_decode", 1'b1, 1'b1, OP_R, ZERO);
    for (int i = 0; i < 3; i++)
      step($sformatf("jal_halt_%0d", i), 1'b1, 1'b1, OP_R, HALT_V);
    cnt = '0;
    step("jal_reset", 1'b0, 1'b0, OP_R, ZERO);
    step("jal_release", 1'b1, 1'b0, OP_R, ZERO);
`endif

    illegal_and_reset();

    run_instr("r2", OP_R, 2, R_EX, R_WB, ZERO);
    step("ld_mid_fetch", 1'b1, 1'b1, OP_LD, FETCH_GO);
    step("ld_mid_decode", 1'b1, 1'b1, OP_BAD, ZERO);
    step("ld_mid_exec", 1'b1, 1'b1, OP_BAD, LD_EX);
    // Reset lands inside the MEM cycle, well before the next rising edge.
    @(posedge clock);
    #2;
    reset = 1'b0;
    cnt = '0;
    q.push_back('{"rst_in_mem", ZERO, cnt});
    step("rst_in_mem_hold", 1'b0, 1'b1, OP_LD, ZERO);
    step("restart_idle", 1'b1, 1'b0, OP_LD, ZERO);
    run_instr("r3", OP_R, 2, R_EX, R_WB, ZERO);
    step("cnt_final", 1'b1, 1'b0, OP_R, ZERO);

    @(posedge clock);
    repeat (3) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uc_multiciclo.md
UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have port `clock`, input, 1 bit: rising-edge clock shared with the PC, IR and register file.
REQ-003 The block SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port `run`, input, 1 bit: permission to start the next instruction; sampled only in FETCH.
REQ-005 The block SHALL have port `opcode`, input, 7 bits: opcode from the instruction memory decode.
REQ-006 The block SHALL have port `weIR`, output, 1 bit: IR load enable.
REQ-007 The block SHALL have port `wePC`, output, 1 bit: PC load enable.
REQ-008 The block SHALL have port `weReg`, output, 1 bit: register-file write enable.
REQ-009 The block SHALL have port `weMem`, output, 1 bit: data-memory write enable.
REQ-010 The block SHALL have port `sinalMux1`, output, 1 bit: ALU B operand select; 0 = doutB, 1 = imm.
REQ-011 The block SHALL have port `sinalMux2`, output, 2 bits: write-back select; 00 = mem, 01 = ALU, 10 = PC+4, 11 = PC+imm.
REQ-012 The block SHALL have port `sinalMux4`, output, 1 bit: branch-adder base; 0 = doutA, 1 = PC.
REQ-013 The block SHALL have port `aluop`, output, 2 bits: 00 = add, 01 = sub/compare, 10 = use funct.
REQ-014 The block SHALL have port `jump`, output, 1 bit: forces PC+imm selection; the datapath ORs it with the ALU flag.
REQ-015 The block SHALL have port `done`, output, 1 bit: one-cycle pulse in the final state of each legal instruction.
REQ-016 The block SHALL have port `erro`, output, 1 bit: sticky illegal-opcode indicator.
REQ-017 The block SHALL have port `instr_count`, output, 16 bits: count of retired instructions.

Function
REQ-018 The state machine SHALL have the states FETCH, DECODE, EXECUTE, MEM, WB and HALT, one state per clock.
REQ-019 In FETCH with run=1, the block SHALL assert weIR, latch opcode into an internal register and go to DECODE. With run=0 it SHALL stay in FETCH with all enables at 0.
REQ-020 DECODE SHALL assert no enables. Next state SHALL be EXECUTE for a legal opcode and HALT otherwise.
REQ-021 Legal opcodes SHALL be 0110011 (R), 0000011 (load), 0100011 (store) and 1100011 (beq).
REQ-022 R-type SHALL follow FETCH-DECODE-EXECUTE-WB, 4 cycles. EXECUTE: aluop=10, sinalMux1=0. WB: same, plus sinalMux2=01, weReg=1, wePC=1.
REQ-023 Load SHALL follow FETCH-DECODE-EXECUTE-MEM-WB, 5 cycles. aluop=00 and sinalMux1=1 SHALL hold throughout. WB: sinalMux2=00, weReg=1, wePC=1.
REQ-024 Store SHALL follow FETCH-DECODE-EXECUTE-MEM, 4 cycles. aluop=00 and sinalMux1=1 SHALL hold throughout. MEM: weMem=1, wePC=1.
REQ-025 Beq SHALL follow FETCH-DECODE-EXECUTE, 3 cycles. EXECUTE: aluop=01, sinalMux1=0, sinalMux4=1, wePC=1, jump=0.
REQ-026 The last state of each path SHALL pulse done, return to FETCH and increment instr_count, which wraps 0xFFFF to 0x0000.
REQ-027 HALT SHALL hold all enables at 0 and erro at 1, and SHALL be left only by reset.
REQ-028 weReg, weMem and wePC SHALL never be high in the same cycle as weIR.
REQ-029 Any output not listed for a state SHALL be 0.

Reset
REQ-030 reset=0 SHALL immediately force state FETCH, opcode register 0, instr_count 0, erro 0 and all enables 0, including mid-instruction.
REQ-031 After reset is released, the first possible weIR SHALL occur on the first rising edge with run=1.

Configuration
REQ-032 With macro UC_JAL_EN defined, opcode 1101111 SHALL be legal and follow FETCH-DECODE-EXECUTE-WB.
- EXECUTE: sinalMux4=1.
- WB: sinalMux4=1, jump=1, sinalMux2=10, weReg=1, wePC=1.
REQ-033 Without UC_JAL_EN, opcode 1101111 SHALL be illegal and go to HALT.

Verification
REQ-034 Release reset, run=1, opcode=0110011 -> weIR in cycle 1; weReg=1, wePC=1, sinalMux2=01 in cycle 4; done pulse; instr_count=1.
REQ-035 Load 0000011 followed by store 0100011 -> 5 cycles then 4 cycles; weMem=1 only in the store MEM cycle; instr_count=2.
REQ-036 Beq 1100011 -> wePC=1, aluop=01, sinalMux4=1 in cycle 3; no weReg or weMem at any point.
REQ-037 Opcode 1111111 -> HALT after DECODE; erro=1 and all enables 0 for 20 cycles; reset clears erro.
REQ-038 Reset asserted during the MEM state of a load -> enables drop without waiting for a clock edge; restart lands in FETCH; instr_count=0.
REQ-039 Preload instr_count to 0xFFFF and retire one instruction -> instr_count=0x0000. Run with and without UC_JAL_EN: opcode 1101111 gives WB with jump=1, or gives erro=1, respectively.
